// File: rtl/piyc_uart_pkg.sv
// Shared definitions for the piyc UART blocks.
//   uart_tx_state_t : transmitter FSM encoding
//   DATA_BITS       : data bits per frame
//   frame_bits()    : total serial bits per frame (start + data + parity + stop)
package piyc_uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_t;

  function automatic int unsigned frame_bits(input logic parity_en);
    return parity_en ? 32'd11 : 32'd10;
  endfunction

endpackage

// File: rtl/piyc_sync_fifo.sv
// Single-clock FIFO with occupancy count. Generic so a receiver can reuse it.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (flushes contents)
//   push, push_data   : write request; ignored while full
//   pop, pop_data     : read request; pop_data shows the head (show-ahead)
//   full, empty, level: status, level is 0..DEPTH
module piyc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (level == LVL_FULL);
  assign empty    = (level == '0);
  // full blocks a push even when a pop happens in the same cycle
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/piyc_uart_tx.sv
// Byte UART transmitter: 8 data bits LSB first, optional parity, 1 stop bit,
// fed through a small FIFO. Frames run back-to-back while data is queued.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   ena                : low blocks the start of new frames (current one finishes)
//   tx_data, tx_valid  : producer byte and strobe
//   tx_ready           : FIFO not full (and not in reset)
//   tx                 : serial line, idle high, straight from a flop
//   busy               : frame on the line or bytes queued
//   fifo_level         : FIFO occupancy
//
// state  | meaning
// IDLE   | line high, waiting for queued data and ena
// START  | start bit (0)
// DATA   | data bits, LSB first, bit_idx selects position
// PARITY | parity bit (only when PARITY_EN)
// STOP   | stop bit (1); may chain straight into START
module piyc_uart_tx
  import piyc_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT    = 3'(DATA_BITS - 1);
  localparam logic          PAR_ODD     = (PARITY_ODD != 0);

  uart_tx_state_t state;
  logic [CW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift_reg;
  logic           parity_bit;
  logic           stop_tail;
  logic           line_nxt;
  logic           bit_end;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_pop;
  logic [7:0]     fifo_dout;

  assign tx_ready = !rst && !fifo_full;

  piyc_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_valid && tx_ready),
    .push_data (tx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign bit_end  = (baud_cnt == '0);
  assign fifo_pop = !fifo_empty && ena &&
                    ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));

  // tx is this value registered, so the line trails the state by one cycle;
  // stop_tail keeps busy up through that trailing stop-bit cycle.
  assign busy = (state != ST_IDLE) || !fifo_empty || stop_tail;

  always_comb begin
    line_nxt = 1'b1;
    case (state)
      ST_START:  line_nxt = 1'b0;
      ST_DATA:   line_nxt = shift_reg[0];
      ST_PARITY: line_nxt = parity_bit;
      default:   line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      stop_tail  <= 1'b0;
      tx         <= 1'b1;
    end else begin
      tx        <= line_nxt;
      stop_tail <= (state != ST_IDLE);
      if (fifo_pop) begin
        state      <= ST_START;
        baud_cnt   <= BAUD_RELOAD;
        bit_idx    <= '0;
        shift_reg  <= fifo_dout;
        parity_bit <= (^fifo_dout) ^ PAR_ODD;
      end else if (state != ST_IDLE) begin
        if (!bit_end) begin
          baud_cnt <= baud_cnt - CW'(1);
        end else begin
          baud_cnt <= BAUD_RELOAD;
          case (state)
            ST_START: begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end
            ST_DATA: begin
              shift_reg <= shift_reg >> 1;
              if (bit_idx == LAST_BIT) begin
                state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end
            ST_PARITY: state <= ST_STOP;
            default: begin
              state    <= ST_IDLE;
              baud_cnt <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_piyc_uart_tx.sv
module tb_piyc_uart_tx;
  import piyc_uart_pkg::*;

  localparam int CPB  = 4;
  localparam int NDUT = 3;   // 0: no parity, 1: even parity, 2: odd parity

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_v   [NDUT];
  logic       ena_v   [NDUT];
  logic       valid_v [NDUT];
  logic       ready_v [NDUT];
  logic       tx_v    [NDUT];
  logic       busy_v  [NDUT];
  logic [7:0] data_v  [NDUT];
  logic [2:0] level_v [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : gen_dut
    piyc_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .PARITY_EN    ((g != 0) ? 1 : 0),
      .PARITY_ODD   ((g == 2) ? 1 : 0),
      .FIFO_DEPTH   (4)
    ) u_dut (
      .clk        (clk),
      .rst        (rst_v[g]),
      .ena        (ena_v[g]),
      .tx_data    (data_v[g]),
      .tx_valid   (valid_v[g]),
      .tx_ready   (ready_v[g]),
      .tx         (tx_v[g]),
      .busy       (busy_v[g]),
      .fifo_level (level_v[g])
    );
  end

  logic [7:0] exp_q   [NDUT][$];
  int         start_q [NDUT][$];
  int         frames_done [NDUT];
  int         exp_frames  [NDUT];
  logic       abort_mon   [NDUT];
  logic       last_par    [NDUT];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Receiver model: a frame is the bit list {0, data LSB first, [parity], 1},
  // each bit lasting CPB cycles; every cycle of the frame is compared.
  task automatic monitor(input int g);
    logic [7:0]  exp_b;
    logic [7:0]  rx_b;
    logic [10:0] bits;
    logic        par_en;
    logic        have_exp;
    logic        aborted;
    int          nb;
    int          bad;
    int          st;
    par_en = (g != 0);
    nb = int'(frame_bits(par_en));
    forever begin
      @(negedge clk);
      if (tx_v[g] === 1'b0) begin
        st = cyc;
        exp_b = 8'h00;
        have_exp = (exp_q[g].size() > 0);
        if (have_exp) exp_b = exp_q[g].pop_front();
        else begin
          checks++;
          errors++;
          $display("FAIL dut%0d_unexpected_frame actual=frame_at_%0d required=idle", g, st);
        end
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = exp_b;
        if (par_en) bits[9] = (^exp_b) ^ (g == 2);
        bad = 0;
        rx_b = 8'h00;
        aborted = 1'b0;
        for (int k = 0; k < nb && !aborted; k++) begin
          for (int c = 0; c < CPB && !aborted; c++) begin
            if (k != 0 || c != 0) @(negedge clk);
            if (abort_mon[g]) aborted = 1'b1;
            else begin
              if (tx_v[g] !== bits[k]) bad++;
              if (c == CPB/2) begin
                if (k >= 1 && k <= 8) rx_b[k-1] = tx_v[g];
                if (par_en && k == 9) last_par[g] = tx_v[g];
              end
            end
          end
        end
        if (!aborted) begin
          if (have_exp) begin
            chk($sformatf("dut%0d_frame_bad_cycles", g), bad, 0);
            chk($sformatf("dut%0d_decoded_byte", g), {24'h0, rx_b}, {24'h0, exp_b});
          end
          start_q[g].push_back(st);
          frames_done[g]++;
        end
      end
    end
  endtask

  // Call at a negedge; returns at the negedge after the push edge.
  task automatic push(input int g, input logic [7:0] b, output logic acc);
    data_v[g]  = b;
    valid_v[g] = 1'b1;
    acc = ready_v[g];
    @(posedge clk);
    if (acc) begin
      exp_q[g].push_back(b);
      exp_frames[g]++;
    end
    @(negedge clk);
    valid_v[g] = 1'b0;
  endtask

  task automatic wait_frames(input int g, input int n, input int limit, input string name);
    int t;
    t = 0;
    while (frames_done[g] < n && t < limit) begin
      @(negedge clk);
      t++;
    end
    chk(name, frames_done[g], (frames_done[g] < n) ? n : frames_done[g]);
  endtask

  task automatic wait_tx_low(input int g, input int limit, output int s);
    int t;
    t = 0;
    while (tx_v[g] !== 1'b0 && t < limit) begin
      @(negedge clk);
      t++;
    end
    s = cyc;
    chk($sformatf("dut%0d_start_seen", g), {31'h0, tx_v[g]}, 0);
  endtask

  task automatic idle_window(input int g, input int n, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx_v[g] !== 1'b1) bad++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic acc;
    int   n, s, f0, sidx, bad;
    for (int g = 0; g < NDUT; g++) begin
      rst_v[g] = 1'b1; ena_v[g] = 1'b1; valid_v[g] = 1'b0; data_v[g] = 8'h00;
      abort_mon[g] = 1'b0; last_par[g] = 1'b0; frames_done[g] = 0; exp_frames[g] = 0;
    end
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none
    repeat (3) @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("dut%0d_reset_tx", g), {31'h0, tx_v[g]}, 1);
      chk($sformatf("dut%0d_reset_busy", g), {31'h0, busy_v[g]}, 0);
      chk($sformatf("dut%0d_reset_level", g), {29'h0, level_v[g]}, 0);
      chk($sformatf("dut%0d_reset_ready", g), {31'h0, ready_v[g]}, 0);
      rst_v[g] = 1'b0;
    end
    @(negedge clk);
    for (int g = 0; g < NDUT; g++)
      chk($sformatf("dut%0d_ready_after_reset", g), {31'h0, ready_v[g]}, 1);

    // single byte 0xA5: latency, frame, busy fall
    n = cyc + 1;
    push(0, 8'hA5, acc);
    chk("a5_accepted", {31'h0, acc}, 1);
    chk("busy_after_push", {31'h0, busy_v[0]}, 1);
    while (cyc < n + 41) @(negedge clk);
    chk("busy_last_stop_cycle", {31'h0, busy_v[0]}, 1);
    @(negedge clk);
    chk("busy_after_frame", {31'h0, busy_v[0]}, 0);
    chk("tx_idle_after_frame", {31'h0, tx_v[0]}, 1);
    wait_frames(0, exp_frames[0], 50, "a5_frame_done");
    if (start_q[0].size() > 0) chk("a5_latency", start_q[0][0] - n, 2);
    repeat (4) @(negedge clk);

    // back-to-back frames
    sidx = start_q[0].size();
    n = cyc + 1;
    push(0, 8'h00, acc); chk("b2b_push0", {31'h0, acc}, 1);
    push(0, 8'hFF, acc); chk("b2b_push1", {31'h0, acc}, 1);
    push(0, 8'h3C, acc); chk("b2b_push2", {31'h0, acc}, 1);
    wait_frames(0, exp_frames[0], 300, "b2b_frames_done");
    if (start_q[0].size() >= sidx + 3) begin
      chk("b2b_first_latency", start_q[0][sidx] - n, 2);
      chk("b2b_gap_1", start_q[0][sidx+1] - start_q[0][sidx], 40);
      chk("b2b_gap_2", start_q[0][sidx+2] - start_q[0][sidx+1], 40);
    end
    repeat (4) @(negedge clk);

    // fill with ena low
    ena_v[0] = 1'b0;
    f0 = frames_done[0];
    for (int i = 0; i < 5; i++) begin
      push(0, 8'($urandom), acc);
      chk($sformatf("full_push%0d_accept", i), {31'h0, acc}, (i < 4) ? 1 : 0);
      if (i == 3) chk("ready_low_when_full", {31'h0, ready_v[0]}, 0);
    end
    chk("level_full", {29'h0, level_v[0]}, 4);
    idle_window(0, 20, bad);
    chk("tx_held_high_ena_low", bad, 0);
    chk("no_frames_ena_low", frames_done[0], f0);
    ena_v[0] = 1'b1;
    wait_frames(0, exp_frames[0], 400, "full_drain_done");
    repeat (4) @(negedge clk);

    // parity: 0x07 even -> 1, odd -> 0; parity frame length 44
    push(1, 8'h07, acc);
    push(2, 8'h07, acc);
    wait_frames(1, exp_frames[1], 100, "even_frame_done");
    wait_frames(2, exp_frames[2], 100, "odd_frame_done");
    chk("even_parity_bit", {31'h0, last_par[1]}, 1);
    chk("odd_parity_bit", {31'h0, last_par[2]}, 0);
    sidx = start_q[1].size();
    push(1, 8'($urandom), acc);
    push(1, 8'($urandom), acc);
    wait_frames(1, exp_frames[1], 200, "parity_b2b_done");
    if (start_q[1].size() >= sidx + 2)
      chk("parity_frame_len", start_q[1][sidx+1] - start_q[1][sidx], 44);
    repeat (4) @(negedge clk);

    // reset in the middle of a frame with bytes queued
    f0 = frames_done[0];
    push(0, 8'($urandom), acc);
    push(0, 8'($urandom), acc);
    push(0, 8'($urandom), acc);
    wait_tx_low(0, 20, s);
    while (cyc < s + 14) @(negedge clk);
    abort_mon[0] = 1'b1;
    rst_v[0] = 1'b1;
    exp_q[0].delete();
    exp_frames[0] -= 3;
    @(negedge clk);
    chk("rst_mid_tx", {31'h0, tx_v[0]}, 1);
    chk("rst_mid_level", {29'h0, level_v[0]}, 0);
    chk("rst_mid_busy", {31'h0, busy_v[0]}, 0);
    rst_v[0] = 1'b0;
    idle_window(0, 60, bad);
    chk("rst_no_more_frames_tx", bad, 0);
    chk("rst_no_more_frames_cnt", frames_done[0], f0);
    abort_mon[0] = 1'b0;

    // ena drop during data of frame 1 with 2 queued
    f0 = frames_done[0];
    push(0, 8'($urandom), acc);
    push(0, 8'($urandom), acc);
    push(0, 8'($urandom), acc);
    wait_tx_low(0, 20, s);
    while (cyc < s + 12) @(negedge clk);
    ena_v[0] = 1'b0;
    wait_frames(0, f0 + 1, 100, "ena_drop_frame_done");
    idle_window(0, 30, bad);
    chk("ena_drop_idle_high", bad, 0);
    chk("ena_drop_one_frame", frames_done[0], f0 + 1);
    chk("ena_drop_level_held", {29'h0, level_v[0]}, 2);
    ena_v[0] = 1'b1;
    wait_frames(0, exp_frames[0], 200, "ena_return_done");

    // randomized traffic across all three configurations
    for (int i = 0; i < 24; i++) begin
      push(int'($urandom_range(0, NDUT-1)), 8'($urandom), acc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    for (int g = 0; g < NDUT; g++) begin
      wait_frames(g, exp_frames[g], 1500, $sformatf("dut%0d_random_done", g));
      chk($sformatf("dut%0d_scoreboard_empty", g), exp_q[g].size(), 0);
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NDUT; g++)
      chk($sformatf("dut%0d_final_busy", g), {31'h0, busy_v[g]}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
